// File: rtl/pulse_note_scheduler.sv
// Pulse-channel note sequencer: walks a writable note table, presenting a phase increment
// and an envelope per note, with durations counted in prescaled frame ticks.
// Optional envelope decay per frame tick is enabled by defining PULSE_SCHED_DECAY_EN.
module pulse_note_scheduler #(
  parameter int unsigned FRAME_DIV  = 416667,
  parameter int unsigned NOTE_COUNT = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter logic [8:0]  ENV_MAX    = 9'd511,
  parameter logic [8:0]  ENV_DECAY  = 9'd16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_phase_delta,
  input  logic [7:0]        i_wr_frames,
  output logic [31:0]       o_phase_delta,
  output logic              o_phase_delta_valid,
  output logic [8:0]        o_envelope,
  output logic [ADDR_W-1:0] o_note_index,
  output logic              o_frame_tick,
  output logic              o_busy
);

  localparam int unsigned PW = $clog2(FRAME_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;

  typedef struct packed {
    logic [31:0] phase;
    logic [7:0]  frames;
  } note_t;

  note_t mem [NOTE_COUNT];
  note_t rd_q;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [7:0]        fl_q, fl_d;
  logic [31:0]       phase_q, phase_d;
  logic              pdv_q, pdv_d;
  logic [8:0]        env_q, env_d;
  logic [8:0]        env_tick;
  logic              tick;

  // Read address is the next index, so the entry is already registered
  // during the single LOAD cycle; a same-edge write yields the old data.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= '{phase: i_wr_phase_delta, frames: i_wr_frames};
    rd_q <= mem[idx_d];
  end

`ifdef PULSE_SCHED_DECAY_EN
  assign env_tick = (env_q > ENV_DECAY) ? (env_q - ENV_DECAY) : 9'd0;
`else
  logic [8:0] unused_decay;
  assign unused_decay = ENV_DECAY;
  assign env_tick     = env_q;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    fl_d    = fl_q;
    phase_d = phase_q;
    pdv_d   = 1'b0;
    env_d   = env_q;
    tick    = 1'b0;
    unique case (state_q)
      IDLE: begin
        env_d = 9'd0;
        if (i_start && !i_stop) begin
          idx_d   = '0;
          pre_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (i_stop) begin
          state_d = IDLE;
          env_d   = 9'd0;
        end else if (rd_q.frames == 8'd0) begin
          // Looping from entry 0 onto an end marker would spin forever.
          if (i_loop && idx_q != '0) idx_d = '0;
          else begin
            state_d = IDLE;
            env_d   = 9'd0;
          end
        end else begin
          state_d = PLAY;
          phase_d = rd_q.phase;
          pdv_d   = 1'b1;
          env_d   = ENV_MAX;
          fl_d    = rd_q.frames;
          pre_d   = '0;
        end
      end
      PLAY: begin
        if (i_stop) begin
          state_d = IDLE;
          env_d   = 9'd0;
          pre_d   = '0;
        end else begin
          tick  = (pre_q == PRE_LAST);
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            fl_d  = fl_q - 8'd1;
            env_d = env_tick;
            if (fl_q == 8'd1) begin
              idx_d   = idx_q + 1'b1;
              state_d = LOAD;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
      fl_q    <= '0;
      phase_q <= '0;
      pdv_q   <= 1'b0;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      fl_q    <= fl_d;
      phase_q <= phase_d;
      pdv_q   <= pdv_d;
      env_q   <= env_d;
    end
  end

  assign o_phase_delta       = phase_q;
  assign o_phase_delta_valid = pdv_q;
  assign o_envelope          = env_q;
  assign o_note_index        = idx_q;
  assign o_frame_tick        = tick;
  assign o_busy              = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_note_scheduler.sv
// Directed bench for pulse_note_scheduler with FRAME_DIV=4 and a 16-entry table.
module tb_pulse_note_scheduler;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_ph = '0;
  logic [7:0]    wr_fr = '0;
  logic [31:0]   ph;
  logic          pv, ftick, busy;
  logic [8:0]    env;
  logic [AW-1:0] idx;

  int n_chk = 0, n_fail = 0;
  int cyc, idle_at, nticks;
  int          vcyc[$];
  logic [31:0] vph[$];
  logic [8:0]  venv[$];
  logic [AW-1:0] vidx[$];
  logic [8:0]  tenv[$];

  pulse_note_scheduler #(.FRAME_DIV(4), .NOTE_COUNT(16), .ADDR_W(AW),
                         .ENV_MAX(9'd511), .ENV_DECAY(9'd200)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_stop(stop), .i_loop(loop),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_phase_delta(wr_ph), .i_wr_frames(wr_fr),
    .o_phase_delta(ph), .o_phase_delta_valid(pv), .o_envelope(env),
    .o_note_index(idx), .o_frame_tick(ftick), .o_busy(busy));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] p, input logic [7:0] f);
    wr_en = 1'b1; wr_addr = a; wr_ph = p; wr_fr = f;
    step();
    wr_en = 1'b0;
  endtask

  task automatic clr();
    cyc = 0; idle_at = -1; nticks = 0;
    vcyc.delete(); vph.delete(); venv.delete(); vidx.delete(); tenv.delete();
  endtask

  // Steps n cycles, recording note starts, ticks and the first idle cycle.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      start = 1'b0;
      cyc++;
      if (pv) begin vcyc.push_back(cyc); vph.push_back(ph); venv.push_back(env); vidx.push_back(idx); end
      if (ftick) begin nticks++; tenv.push_back(env); end
      if (!busy && idle_at < 0) idle_at = cyc;
    end
  endtask

  task automatic go(input int n);
    clr();
    start = 1'b1;
    run(n);
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    n_chk++; if ({ph, pv, env, idx, ftick, busy} !== '0) begin n_fail++;
      $display("FAIL reset_outputs: got %h exp 0", {ph, pv, env, idx, ftick, busy}); end
  endtask

  task automatic test_reset_mid();
    wr(0, 32'h0000_000A, 8'd3); wr(1, 32'h0, 8'd0);
    loop = 1'b0;
    go(6);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b exp 1", busy); end
    rst = 1'b1; step(); rst = 1'b0;
    n_chk++; if ({ph, pv, env, idx, ftick, busy} !== '0) begin n_fail++;
      $display("FAIL reset_mid_outputs: got %h exp 0", {ph, pv, env, idx, ftick, busy}); end
    go(20);
    n_chk++; if (vcyc[0] !== 2 || vph[0] !== 32'hA) begin n_fail++;
      $display("FAIL restart_note: got cyc %0d ph %h exp cyc 2 ph a", vcyc[0], vph[0]); end
    n_chk++; if (idle_at !== 15) begin n_fail++; $display("FAIL restart_idle: got %0d exp 15", idle_at); end
  endtask

  task automatic test_sequence();
    wr(0, 32'h0100_0000, 8'd2); wr(1, 32'h0200_0000, 8'd1); wr(2, 32'h0, 8'd0);
    loop = 1'b0;
    go(20);
    n_chk++; if (vcyc.size() !== 2) begin n_fail++; $display("FAIL seq_valid_count: got %0d exp 2", vcyc.size()); end
    n_chk++; if (vcyc[0] !== 2 || vph[0] !== 32'h0100_0000) begin n_fail++;
      $display("FAIL seq_note0: got cyc %0d ph %h exp cyc 2 ph 01000000", vcyc[0], vph[0]); end
    n_chk++; if (vcyc[1] !== 11 || vph[1] !== 32'h0200_0000) begin n_fail++;
      $display("FAIL seq_note1: got cyc %0d ph %h exp cyc 11 ph 02000000", vcyc[1], vph[1]); end
    n_chk++; if (idle_at !== 16) begin n_fail++; $display("FAIL seq_idle: got %0d exp 16", idle_at); end
    n_chk++; if (nticks !== 3) begin n_fail++; $display("FAIL seq_ticks: got %0d exp 3", nticks); end
    n_chk++; if (env !== 9'd0) begin n_fail++; $display("FAIL seq_idle_env: got %0d exp 0", env); end
  endtask

  task automatic test_loop();
    loop = 1'b1;
    go(20);
    n_chk++; if (vcyc[2] !== 17 || vph[2] !== 32'h0100_0000) begin n_fail++;
      $display("FAIL loop_restart: got cyc %0d ph %h exp cyc 17 ph 01000000", vcyc[2], vph[2]); end
    n_chk++; if (idle_at !== -1) begin n_fail++; $display("FAIL loop_no_idle: got %0d exp -1", idle_at); end
    stop = 1'b1; step(); stop = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_stop: got %b exp 0", busy); end
    wr(0, 32'h0300_0000, 8'd0);
    go(6);
    n_chk++; if (vcyc.size() !== 0) begin n_fail++; $display("FAIL empty_valid: got %0d exp 0", vcyc.size()); end
    n_chk++; if (idle_at !== 2) begin n_fail++; $display("FAIL empty_idle: got %0d exp 2", idle_at); end
  endtask

  task automatic test_envelope();
    logic [8:0] exp_env [4];
`ifdef PULSE_SCHED_DECAY_EN
    exp_env = '{9'd511, 9'd311, 9'd111, 9'd0};
`else
    exp_env = '{9'd511, 9'd511, 9'd511, 9'd511};
`endif
    wr(0, 32'h44, 8'd4); wr(1, 32'h55, 8'd1); wr(2, 32'h0, 8'd0);
    loop = 1'b0;
    go(26);
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (tenv[k] !== exp_env[k]) begin n_fail++;
        $display("FAIL env_frame%0d: got %0d exp %0d", k, tenv[k], exp_env[k]); end
    end
    n_chk++; if (vcyc[1] !== 19 || venv[1] !== 9'd511) begin n_fail++;
      $display("FAIL env_reload: got cyc %0d env %0d exp cyc 19 env 511", vcyc[1], venv[1]); end
    n_chk++; if (tenv[4] !== 9'd511) begin n_fail++; $display("FAIL env_note1: got %0d exp 511", tenv[4]); end
  endtask

  task automatic test_stop_and_write();
    wr(0, 32'h11, 8'd1); wr(1, 32'h22, 8'd2); wr(2, 32'h0, 8'd0);
    loop = 1'b1;
    go(7);
    wr_en = 1'b1; wr_addr = 1; wr_ph = 32'h33; wr_fr = 8'd2;
    run(1);
    wr_en = 1'b0;
    run(17);
    n_chk++; if (ph !== 32'h33) begin n_fail++; $display("FAIL wr_cur_phase: got %h exp 33", ph); end
    n_chk++; if (vph[1] !== 32'h22 || vcyc[1] !== 7) begin n_fail++;
      $display("FAIL wr_old_value: got cyc %0d ph %h exp cyc 7 ph 22", vcyc[1], vph[1]); end
    n_chk++; if (vph[3] !== 32'h33 || vcyc[3] !== 22) begin n_fail++;
      $display("FAIL wr_new_value: got cyc %0d ph %h exp cyc 22 ph 33", vcyc[3], vph[3]); end
    n_chk++; if (ftick !== 1'b1) begin n_fail++; $display("FAIL pre_stop_tick: got %b exp 1", ftick); end
    stop = 1'b1; start = 1'b1; #1;
    n_chk++; if (ftick !== 1'b0) begin n_fail++; $display("FAIL stop_tick_suppress: got %b exp 0", ftick); end
    step(); stop = 1'b0; start = 1'b0;
    n_chk++; if (busy !== 1'b0 || env !== 9'd0) begin n_fail++;
      $display("FAIL stop_start: got busy %b env %0d exp busy 0 env 0", busy, env); end
    n_chk++; if (ph !== 32'h33) begin n_fail++; $display("FAIL idle_hold_phase: got %h exp 33", ph); end
    step();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_stays_idle: got %b exp 0", busy); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 16; k++) wr(AW'(k), 32'(k + 1), 8'd1);
    loop = 1'b0;
    go(85);
    n_chk++; if (vidx.size() !== 17) begin n_fail++; $display("FAIL wrap_count: got %0d exp 17", vidx.size()); end
    for (int k = 0; k < 17; k++) begin
      n_chk++; if (vidx[k] !== AW'(k % 16)) begin n_fail++;
        $display("FAIL wrap_index%0d: got %0d exp %0d", k, vidx[k], k % 16); end
    end
    n_chk++; if (idle_at !== -1) begin n_fail++; $display("FAIL wrap_no_idle: got %0d exp -1", idle_at); end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_sequence();
    test_loop();
    test_envelope();
    test_stop_and_write();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_note_scheduler.md
Name: pulse_note_scheduler

Overview:
Sequences a pulse channel from a small writable note table. It steps through the entries and, for each note, presents a phase increment to the phase generator and a 9-bit envelope to the duty-compare stage. Note durations are counted in frame ticks, which come from an internal prescaler. The block replaces a fixed-song sequencer, so software or a loader FSM can rewrite the song at runtime.

Parameters:
FRAME_DIV, 416667, clock cycles per frame tick (25 MHz / 60 Hz); must be >= 2
NOTE_COUNT, 16, table depth; power of two, 2..256
ADDR_W, 4, log2(NOTE_COUNT)
ENV_MAX, 9'd511, envelope value loaded at note start
ENV_DECAY, 9'd16, envelope decrement per frame tick (decay feature only)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_start  in  1  start playback from entry 0 (level-sampled; honoured only in IDLE)
i_stop  in  1  abort playback
i_loop  in  1  on end marker: 1 = restart at entry 0, 0 = stop
i_wr_en  in  1  table write strobe
i_wr_addr  in  ADDR_W  table write address
i_wr_phase_delta  in  32  phase increment to store
i_wr_frames  in  8  duration in frames to store; 0 = end marker
o_phase_delta  out  32  current phase increment
o_phase_delta_valid  out  1  1-cycle pulse when o_phase_delta changes
o_envelope  out  9  current envelope/compare amplitude
o_note_index  out  ADDR_W  entry currently playing
o_frame_tick  out  1  1-cycle pulse per frame while busy
o_busy  out  1  high in LOAD or PLAY

Behaviour:
- Synchronous active-high reset on i_reset: state IDLE; all outputs 0; prescaler 0; frame counter 0; index 0. Table RAM is not reset.
- Table write: one synchronous write port, writable in any state. Read is registered with 1-cycle latency. A write to the entry currently playing takes effect on the next LOAD of that entry.
- FSM states: IDLE, LOAD, PLAY.
- IDLE:
  - o_busy=0; o_envelope=0; o_phase_delta holds its last value.
  - i_start=1 -> index<=0, prescaler<=0, go to LOAD.
- LOAD (exactly 1 cycle; table read issued here):
  - If the entry's frames==0 and i_loop=1 and index!=0: index<=0, stay in LOAD.
  - If the entry's frames==0 and (i_loop=0 or index==0): go to IDLE. This avoids livelock on an empty table.
  - Otherwise go to PLAY. On entry to PLAY: o_phase_delta<=entry, o_phase_delta_valid=1 for one cycle, o_envelope<=ENV_MAX, frames_left<=entry frames, prescaler<=0.
- PLAY:
  - The prescaler counts 0..FRAME_DIV-1. o_frame_tick pulses on the cycle the count wraps, so the first tick comes FRAME_DIV cycles after PLAY entry.
  - On each tick, frames_left decrements and the envelope updates (see Optional Feature).
  - A tick with frames_left==1: index<=index+1 (wraps NOTE_COUNT-1 -> 0), go to LOAD.
  - Note latency: total cycles per note = frames*FRAME_DIV + 1 (the LOAD cycle). A wrap from the last entry plays entry 0 again without needing an end marker.
- i_stop=1 in any state: next state IDLE, o_envelope<=0, o_frame_tick suppressed. i_stop has priority over i_start and over tick processing in the same cycle.
- i_reset has priority over everything, including when asserted mid-note.
- Simultaneous i_wr_en and a LOAD read of the same address: the read returns the old data (read-before-write).
- o_note_index updates with the index register.

Optional Feature:
Macro PULSE_SCHED_DECAY_EN.
- Defined: on each frame tick in PLAY, o_envelope <= o_envelope - ENV_DECAY, saturating at 0 (no underflow wrap).
- Undefined: o_envelope stays at ENV_MAX for the whole note. ENV_DECAY is unused, and the decay subtractor and comparator are not built.

Test Plan:
1. Reset mid-PLAY (FRAME_DIV=4) -> the cycle after i_reset, all outputs 0 and o_busy=0. A subsequent i_start plays entry 0 normally.
2. Table {0:(0x01000000,2), 1:(0x02000000,1), 2:(x,0)}, i_loop=0, i_start -> phase_delta_valid pulses with 0x01000000, then 9 cycles later with 0x02000000. IDLE is reached 5 cycles after that. o_frame_tick count is 3.
3. Same table with i_loop=1 -> after entry 1, the LOAD of entry 2 hits the end marker, index goes to 0, and 0x01000000 is re-presented. Empty table (entry 0 frames=0) with i_loop=1 -> returns to IDLE, no valid pulse.
4. PULSE_SCHED_DECAY_EN, ENV_DECAY=200, note of 4 frames -> o_envelope sequence 511, 311, 111, 0, then reload 511 at the next note. Without the macro -> constant 511.
5. i_stop and i_start asserted together during PLAY -> IDLE, envelope 0. A write to entry 1 while entry 1 plays -> the new value appears only on its next load.
6. NOTE_COUNT=16, all frames=1, i_loop=0 -> index wraps 15 -> 0 with no IDLE. o_note_index counts 0..15,0.
